// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight to a
// variable-latency instruction memory and presents pcadd/inst to the IF/ID register.
module if_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcwrite,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [PC_W-1:0]   pcadd,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              fetch_stall
);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     pcadd_q, pcadd_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                inst_valid_q, inst_valid_d;
    logic [PC_W-1:0]     pc_inc;

    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pcadd_d      = pcadd_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            ISSUE: begin
                if (redirect) pc_d = redirect_pc;
                else          state_d = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    // a response landing together with the redirect is stale; nothing left to drain
                    state_d = imem_rvalid ? ISSUE : DROP;
                end else if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    pcadd_d      = pc_inc;
                    inst_valid_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                    state_d      = ISSUE;
                end else if (pcwrite) begin
                    pc_d         = pc_inc;
                    inst_valid_d = 1'b0;
                    state_d      = ISSUE;
                end
            end
            DROP: begin
                if (redirect)    pc_d = redirect_pc;
                if (imem_rvalid) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ISSUE;
            pc_q         <= RESET_PC;
            pcadd_q      <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pcadd_q      <= pcadd_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Request is gated by a same-cycle redirect so a stale address never goes out.
    assign imem_req    = rst_n && (state_q == ISSUE) && !redirect;
    assign imem_addr   = pc_q;
    assign pcadd       = pcadd_q;
    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign fetch_stall = ~inst_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, checked against a
// transaction-level model (next fetch address, in-flight request, presented word).
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcwrite, redirect, imem_rvalid;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [7:0]  pcadd;
    logic [31:0] inst;
    logic        inst_valid, fetch_stall;

    if_fetch_unit #(.PC_W(8), .INST_W(32), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .pcwrite(pcwrite), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pcadd(pcadd),
        .inst(inst), .inst_valid(inst_valid), .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    // memory model
    logic [31:0] mem [256];
    logic [7:0]  resp_addr;
    int          cd = 0;
    int          lat = 1;
    logic        rand_lat = 1'b0;

    // reference model
    logic [7:0]  next_m = 8'h00;
    logic        out_m = 1'b0, out_kill = 1'b0;
    logic [7:0]  out_addr = 8'h00;
    logic        pres_m = 1'b0;
    logic [7:0]  pres_addr = 8'h00;

    int   nvec = 0, nerr = 0;
    int   cyc = 0, last_req = -1;
    logic cad = 1'b0, saw_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic pw, input logic rd, input logic [7:0] rpc, input logic rv);
        logic [7:0] exp_pcadd;
        logic       new_req;
        logic [7:0] new_addr;
        @(posedge clk); #1;
        rst_n = rv; pcwrite = pw; redirect = rd; redirect_pc = rpc;
        imem_rvalid = 1'b0; imem_rdata = $urandom;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin imem_rvalid = 1'b1; imem_rdata = mem[resp_addr]; end
        end
        if (!rv) begin pres_m = 1'b0; out_m = 1'b0; next_m = 8'h00; end
        @(negedge clk);
        chk("inst_valid", inst_valid, pres_m);
        chk("fetch_stall", fetch_stall, !pres_m);
        if (pres_m) begin
            exp_pcadd = pres_addr + 8'd1;
            chk("inst", inst, mem[pres_addr]);
            chk("pcadd", pcadd, exp_pcadd);
        end
        if (!rst_n) begin
            chk("rst_req", imem_req, 0);
            chk("rst_pcadd", pcadd, 0);
            chk("rst_inst", inst, 0);
        end else begin
            if (redirect) chk("req_gated", imem_req, 0);
            else if (!out_m && !pres_m) chk("req_expected", imem_req, 1);
            if (imem_req) begin
                chk("req_addr", imem_addr, next_m);
                chk("one_outstanding", out_m | pres_m, 0);
                if (cad && last_req < 0) chk("first_req_cycle", cyc, 0);
                if (cad && last_req >= 0) chk("req_cadence", cyc - last_req, 3);
                last_req = cyc;
            end
        end
        new_req  = rst_n && imem_req;
        new_addr = next_m;
        if (new_req) begin
            saw_req = 1'b1; resp_addr = imem_addr;
            cd = rand_lat ? int'($urandom_range(1, 4)) : lat;
        end
        if (rst_n) begin
            if (redirect) begin
                next_m = redirect_pc; pres_m = 1'b0;
                if (out_m) out_kill = 1'b1;
            end else if (pres_m && pcwrite) begin
                pres_m = 1'b0; next_m = pres_addr + 8'd1;
            end
            if (imem_rvalid && out_m) begin
                if (!out_kill) begin pres_m = 1'b1; pres_addr = out_addr; end
                out_m = 1'b0;
            end
            if (new_req) begin out_m = 1'b1; out_addr = new_addr; out_kill = 1'b0; end
        end
        cyc++;
    endtask

    task automatic run_until_req(input int max);
        int n = 0;
        saw_req = 1'b0;
        do begin step(1'b1, 1'b0, 8'h00, 1'b1); n++; end while (!saw_req && n < max);
        chk("req_timeout", saw_req, 1);
    endtask

    task automatic run_until_pres(input int max);
        int n = 0;
        while (!pres_m && n < max) begin step(1'b1, 1'b0, 8'h00, 1'b1); n++; end
        chk("pres_timeout", pres_m, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[4] = 32'h8C220004;
        rst_n = 1'b0; pcwrite = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);

        // back-to-back fetch, latency 1: requests every 3 cycles
        cyc = 0; cad = 1'b1; lat = 1;
        repeat (9) step(1'b1, 1'b0, 8'h00, 1'b1);
        cad = 1'b0;

        // load-use hold while presenting address 4
        for (int n = 0; n < 40 && !(pres_m && pres_addr == 8'h04); n++)
            step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("hold_reach", pres_addr, 8'h04);
        repeat (4) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("hold_inst", inst, 32'h8C220004);
            chk("hold_pcadd", pcadd, 8'h05);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        run_until_req(10);
        chk("after_hold_addr", imem_addr, 8'h05);

        // redirect in the 2nd WAIT cycle with latency 3
        lat = 3;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h40, 1'b1);
        run_until_pres(20);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("redir_wait_pcadd", pcadd, 8'h41);

        // redirect coincident with the response
        lat = 2;
        run_until_req(10);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h10, 1'b1);
        run_until_req(10);
        chk("redir_rvalid_addr", imem_addr, 8'h10);
        run_until_pres(10);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("redir_rvalid_pcadd", pcadd, 8'h11);

        // PC wrap-around
        lat = 1;
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        run_until_pres(10);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_pcadd", pcadd, 8'h00);
        run_until_req(10);
        chk("wrap_next_addr", imem_addr, 8'h00);

        // reset during WAIT, stale response arrives right after release
        lat = 3;
        run_until_req(10);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        saw_req = 1'b0;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("restart_req", saw_req, 1);
        chk("restart_addr", imem_addr, 8'h00);
        run_until_pres(10);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("restart_pcadd", pcadd, 8'h01);

        // random traffic
        rand_lat = 1'b1;
        repeat (600)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
                 8'($urandom), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the pcadd/inst pair consumed by the IF/ID pipeline register. It owns the PC and issues one word-addressed request at a time to an instruction memory with variable response latency. It honours load-use holds (pcwrite) and branch/jump redirects. It raises fetch_stall whenever no valid instruction is presented, so IF/ID latches a bubble in that cycle.

Parameters:
PC_W, 8, PC / word-address width
INST_W, 32, instruction width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pcwrite  in  1  1 = IF/ID accepts the presented instruction this edge; 0 = hold (load-use)
redirect  in  1  branch/jump taken; highest priority
redirect_pc  in  PC_W  redirect target (word address)
imem_req  out  1  fetch request strobe, one cycle per request
imem_addr  out  PC_W  fetch address, always equals internal pc
imem_rvalid  in  1  response valid, at least 1 cycle after imem_req
imem_rdata  in  INST_W  response data, valid with imem_rvalid
pcadd  out  PC_W  pc+1 of presented instruction, to IF/ID pcadd
inst  out  INST_W  presented instruction, to IF/ID inst
inst_valid  out  1  pcadd/inst hold a live instruction
fetch_stall  out  1  equals ~inst_valid; ORed into the IF/ID stall input

Behaviour:
- Reset: clk and rst_n are named exactly as given. Reset is asynchronous and active-low. While rst_n=0: pc=RESET_PC, state=ISSUE, pcadd=0, inst=0, inst_valid=0, fetch_stall=1. imem_req=0 while rst_n=0.
- States: ISSUE, WAIT, HOLD, DROP. Registered outputs: pcadd, inst, inst_valid. imem_req is decoded from the state. A single outstanding request at most.
- ISSUE:
  - imem_req=1 for exactly this cycle, with imem_addr=pc.
  - Next state is WAIT.
  - If redirect=1: no request is counted, pc<=redirect_pc, stay in ISSUE. imem_req is gated to 0 in this cycle.
- WAIT:
  - imem_rvalid=1 and redirect=0: inst<=imem_rdata, pcadd<=pc+1 (mod 2^PC_W), inst_valid<=1, go to HOLD.
  - redirect=1 and imem_rvalid=0: pc<=redirect_pc, go to DROP.
  - redirect=1 and imem_rvalid=1: discard the response, pc<=redirect_pc, go to ISSUE.
- HOLD:
  - Instruction is presented.
  - pcwrite=1 and redirect=0: the instruction is consumed at this edge. pc<=pc+1, inst_valid<=0, go to ISSUE.
  - pcwrite=0: hold everything unchanged, for any number of cycles.
  - redirect=1: pc<=redirect_pc, inst_valid<=0, go to ISSUE. pcwrite is ignored.
- DROP:
  - Wait for the stale response.
  - imem_rvalid=1: discard, go to ISSUE.
  - redirect=1: pc<=redirect_pc. Stay in DROP, or go to ISSUE if imem_rvalid=1 in the same cycle.
- pcwrite is ignored in ISSUE, WAIT and DROP.
- inst/pcadd keep their last values when inst_valid=0. They are not zeroed; IF/ID zeroes the bubble through fetch_stall.
- imem_rvalid in ISSUE or HOLD is a protocol violation and is ignored; no state change.
- Wrap-around: pc=2^PC_W-1 gives pcadd=0, and the next pc is 0.
- Minimum throughput: 3 cycles per instruction with 1-cycle memory latency (ISSUE, WAIT, HOLD).
- Reset asserted mid-request: all state is cleared immediately. A late imem_rvalid arriving after release, while in ISSUE, is ignored.

Test Plan:
- Reset release, memory latency 1, pcwrite=1 constant. Required: imem_req at cycles 0, 3, 6 with imem_addr 0, 1, 2. inst_valid pulses carry pcadd 1, 2, 3 with the matching rdata. fetch_stall=1 in all other cycles.
- pcwrite=0 for 4 cycles while in HOLD with inst=0x8C220004, pcadd=0x05. Required: outputs stable, no imem_req. After pcwrite=1: next request has addr 0x05.
- Memory latency 3; redirect to 0x40 in the 2nd WAIT cycle. Required: the stale response is discarded, inst_valid stays 0, next request has addr 0x40, and the presented pcadd is 0x41.
- Redirect to 0x10 in the same cycle as imem_rvalid. Required: the response is dropped, state goes to ISSUE with addr 0x10, and no inst_valid pulse occurs for the old data.
- pc=0xFF fetch. Required: pcadd=0x00; after consumption the next imem_addr is 0x00.
- Assert rst_n=0 during WAIT, with a response arriving 2 cycles later. Required: outputs go to 0 immediately, the response is ignored, and fetch restarts at RESET_PC.
